// File: rtl/vec_alu_sequencer_if.sv
// Handshake and ALU-drive bundle for the vector ALU issue sequencer.
// The sequencer uses the slave view; the requester/ALU environment uses the master view.
interface vec_alu_sequencer_if #(
    parameter int N     = 8,
    parameter int LANES = 4
);
    logic                   start_valid_i;
    logic                   start_ready_o;
    logic [2:0]             opcode_i;
    logic [LANES*N-1:0]     va_i;
    logic [LANES*N-1:0]     vb_i;
    logic [N-1:0]           alu_a_o;
    logic [N-1:0]           alu_b_o;
    logic [2:0]             alu_opcode_o;
    logic [N-1:0]           alu_result_i;
    logic [1:0]             alu_flags_i;
    logic                   done_valid_o;
    logic                   done_ready_i;
    logic [LANES*N-1:0]     vres_o;
    logic [2*LANES-1:0]     vflags_o;
    logic                   cmp_eq_o;
    logic                   busy_o;

    modport slave (
        input  start_valid_i, opcode_i, va_i, vb_i, alu_result_i, alu_flags_i, done_ready_i,
        output start_ready_o, alu_a_o, alu_b_o, alu_opcode_o, done_valid_o,
               vres_o, vflags_o, cmp_eq_o, busy_o
    );

    modport master (
        output start_valid_i, opcode_i, va_i, vb_i, alu_result_i, alu_flags_i, done_ready_i,
        input  start_ready_o, alu_a_o, alu_b_o, alu_opcode_o, done_valid_o,
               vres_o, vflags_o, cmp_eq_o, busy_o
    );
endinterface

// File: rtl/vec_alu_sequencer.sv
// Vector issue sequencer: latches one vector op, drives the shared combinational ALU
// one lane per cycle (lane 0 first) and returns the collected results over a handshake.
module vec_alu_sequencer #(
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    vec_alu_sequencer_if.slave   bus
);
    localparam int         LANE_W = $clog2(LANES);
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    logic [LANE_W-1:0]    lane_cnt_r;
    logic [2:0]           opcode_r;
    logic [LANES*N-1:0]   va_r;
    logic [LANES*N-1:0]   vb_r;
    logic [LANES*N-1:0]   vres_r;
    logic [2*LANES-1:0]   vflags_r;
    logic                 cmp_eq_r;
    logic                 start_ready_r;
    logic                 done_valid_r;
    logic                 busy_r;

    logic [N-1:0]         lane_a_s;
    logic [N-1:0]         lane_b_s;
    logic [LANES*N-1:0]   vres_next_s;
    logic [2*LANES-1:0]   vflags_next_s;
    logic                 zero_all_s;
    logic                 is_cmp_s;

    assign is_cmp_s = (opcode_r == OP_CMP);

    // Select the current lane's operands and merge this cycle's ALU result into the vectors.
    always_comb begin
        lane_a_s      = '0;
        lane_b_s      = '0;
        vres_next_s   = vres_r;
        vflags_next_s = vflags_r;
        zero_all_s    = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if (lane_cnt_r == LANE_W'(l)) begin
                lane_a_s                = va_r[l*N +: N];
                lane_b_s                = vb_r[l*N +: N];
                vres_next_s[l*N +: N]   = bus.alu_result_i;
                // Flags are undefined (possibly Z) for non-CMP ops, so never register them.
                vflags_next_s[2*l +: 2] = is_cmp_s ? bus.alu_flags_i : 2'b00;
            end else begin
                vflags_next_s[2*l +: 2] = vflags_next_s[2*l +: 2];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            zero_all_s = zero_all_s & vflags_next_s[2*l];
        end
    end

    // Sequencer FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            lane_cnt_r    <= '0;
            opcode_r      <= 3'd0;
            va_r          <= '0;
            vb_r          <= '0;
            vres_r        <= '0;
            vflags_r      <= '0;
            cmp_eq_r      <= 1'b0;
            start_ready_r <= 1'b1;
            done_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_valid_i) begin
                        opcode_r      <= bus.opcode_i;
                        va_r          <= bus.va_i;
                        vb_r          <= bus.vb_i;
                        lane_cnt_r    <= '0;
                        vres_r        <= '0;
                        vflags_r      <= '0;
                        cmp_eq_r      <= 1'b0;
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    vres_r   <= vres_next_s;
                    vflags_r <= vflags_next_s;
                    if (lane_cnt_r == LAST_LANE) begin
                        cmp_eq_r     <= is_cmp_s & zero_all_s;
                        done_valid_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        lane_cnt_r <= lane_cnt_r + LANE_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.done_ready_i) begin
                        done_valid_r  <= 1'b0;
                        busy_r        <= 1'b0;
                        start_ready_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    lane_cnt_r    <= '0;
                    done_valid_r  <= 1'b0;
                    busy_r        <= 1'b0;
                    start_ready_r <= 1'b1;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready_o = start_ready_r;
    assign bus.done_valid_o  = done_valid_r;
    assign bus.busy_o        = busy_r;
    assign bus.vres_o        = vres_r;
    assign bus.vflags_o      = vflags_r;
    assign bus.cmp_eq_o      = cmp_eq_r;
    assign bus.alu_a_o       = (state_r == ST_ISSUE) ? lane_a_s : '0;
    assign bus.alu_b_o       = (state_r == ST_ISSUE) ? lane_b_s : '0;
    assign bus.alu_opcode_o  = opcode_r;
endmodule

// File: doc/vec_alu_sequencer.md
# vec_alu_sequencer

Issue sequencer for the vector datapath. It accepts one vector operation per handshake: an opcode plus two operand vectors of `LANES` elements, each `N` bits wide. It then drives the shared scalar ALU one lane per cycle, with lane 0 first. It collects each lane's result and flags into a result vector and presents that vector on an output handshake. It acts as the initiator on the ALU's operand/opcode interface: the ALU is purely combinational, and this block supplies its `a`, `b` and `opcode` and samples its `result` and `ALUFlags`.

## Interface
Parameters:
- `N`, default 8: element width; must match the ALU's `N`.
- `LANES`, default 4: elements per vector, at least 2.

Ports:
- `clk_i`  in  1: single clock, rising edge.
- `rst_ni`  in  1: reset, asynchronous and active-low.
- `start_valid_i`  in  1: a new vector operation is presented.
- `start_ready_o`  out  1: the block can accept an operation; high only in IDLE.
- `opcode_i`  in  3: operation, using `alu_defs` encodings (ADD, MOV, XOR, OR, SHR, SHL, CMP).
- `va_i`  in  LANES*N: operand A vector; lane l occupies bits [l*N +: N].
- `vb_i`  in  LANES*N: operand B vector, same packing as `va_i`.
- `alu_a_o`  out  N: ALU operand A.
- `alu_b_o`  out  N: ALU operand B.
- `alu_opcode_o`  out  3: ALU opcode.
- `alu_result_i`  in  N: ALU result.
- `alu_flags_i`  in  2: ALU flags; [0] = zero, [1] = sign; valid only when the opcode is CMP.
- `done_valid_o`  out  1: the result vector is available.
- `done_ready_i`  in  1: the consumer accepts the result vector.
- `vres_o`  out  LANES*N: result vector, same packing as `va_i`.
- `vflags_o`  out  2*LANES: per-lane flags; lane l occupies bits [2l +: 2] as {sign, zero}.
- `cmp_eq_o`  out  1: AND of all lane zero flags; 0 for any non-CMP operation.
- `busy_o`  out  1: high in ISSUE or DONE.

## Operation
- The FSM has three states: IDLE, ISSUE and DONE.
- IDLE:
  - `start_ready_o` = 1.
  - When `start_valid_i` and `start_ready_o` are both high at a clock edge, the block latches `opcode_i`, `va_i` and `vb_i`.
  - On that same edge it clears `lane_cnt` to 0, `vres_o` to 0, `vflags_o` to 0 and `cmp_eq_o` to 0, then enters ISSUE.
- ISSUE:
  - Combinationally, `alu_a_o` = latched A lane `lane_cnt`, `alu_b_o` = latched B lane `lane_cnt`, and `alu_opcode_o` = latched opcode.
  - At each edge the block writes `alu_result_i` into `vres_o` lane `lane_cnt`.
  - If the latched opcode is CMP, it writes `alu_flags_i` into `vflags_o` lane `lane_cnt`. Otherwise it writes 2'b00, so high-impedance flag values never enter a register.
  - `lane_cnt` then increments.
  - At the edge that captures lane `LANES-1`, the block enters DONE. `cmp_eq_o` is updated on that edge from the completed zero flags, including the final lane's.
- DONE:
  - `done_valid_o` = 1; `vres_o`, `vflags_o` and `cmp_eq_o` are held stable.
  - When `done_valid_o` and `done_ready_i` are both high at an edge, the block returns to IDLE.
  - `start_valid_i` is ignored here, because `start_ready_o` = 0.
- Outside ISSUE, `alu_a_o` and `alu_b_o` are 0 and `alu_opcode_o` holds the last latched opcode (reset value 0).
- Arithmetic is entirely the ALU's; operands pass through unmodified, including full N-bit shift amounts. The sequencer applies no carry or widening.
- After return to IDLE, `vres_o`, `vflags_o` and `cmp_eq_o` keep their last values until the next accept.
- `lane_cnt` is $clog2(LANES) bits wide and never wraps inside an operation; it is reset at each accept.

## Timing
- Reset (`rst_ni` low, asynchronous):
  - State goes to IDLE and `lane_cnt` = 0.
  - `vres_o` = 0, `vflags_o` = 0, `cmp_eq_o` = 0.
  - `done_valid_o` = 0, `busy_o` = 0, `start_ready_o` = 1.
  - All ALU drive outputs = 0.
  - Inputs are ignored while reset is asserted.
- Reset mid-ISSUE or mid-DONE: the operation is aborted, no `done_valid_o` pulse occurs, and partial results are cleared.
- Latency: for an accept at edge e0, lanes are captured at edges e1..eLANES, and `done_valid_o` rises after edge eLANES.
- Throughput: with `done_ready_i` and `start_valid_i` held high, one vector completes every LANES+2 cycles, made up of LANES issue cycles, 1 DONE cycle and 1 IDLE cycle.
- `done_valid_o` never drops without a handshake.
- `start_ready_o` is a registered-state decode with no combinational path from `start_valid_i`.
- The ALU path (`alu_*_o` to `alu_result_i`/`alu_flags_i`) is a single combinational cycle that must close at `clk_i`.

## Test plan
Tests 1–5 use N=8, LANES=4.
- ADD, `va_i`=0x04030201, `vb_i`=0x10101010:
  - `vres_o`=0x14131211, `vflags_o`=0x00, `cmp_eq_o`=0.
  - `done_valid_o` asserts 4 cycles after the accept edge.
- CMP, `va_i`=0x05050505, `vb_i`=0x05050A05:
  - Lane 1 gives 0xFB with sign=1; the other lanes give zero=1.
  - `vflags_o`=0x59, `cmp_eq_o`=0, `vres_o`=0x0000FB00.
- CMP, `va_i`=`vb_i`=0xA5A5A5A5: `vflags_o`=0x55 and `cmp_eq_o`=1. A following XOR op then returns `cmp_eq_o`=0.
- Backpressure: hold `done_ready_i` low for 5 cycles in DONE with `start_valid_i` high.
  - `done_valid_o` stays 1 and `vres_o` stays stable.
  - `start_ready_o`=0 and no new op is latched.
  - Completion occurs on the edge where `done_ready_i` rises.
- Reset mid-op: assert `rst_ni` low while lane 2 is issuing.
  - All outputs go to their reset values immediately and no done is produced.
  - A fresh SHL op, `va_i`=0x01010101, `vb_i`=0x03020100, afterwards gives `vres_o`=0x08040201.
- Back-to-back: issue three ops (MOV, OR, SHR) with the handshakes held high. Accepts must be spaced exactly 6 cycles apart, and each result must be correct.
